snes_pad_responder: RTL and testbench

- Device-side counterpart of the SNES controller interface: it emulates a game pad on the serial link.
- It accepts data_latch and data_clock from an external host or console and shifts out a 16-bit button word, active-low, on serial_data.
- It runs on the GBA system clock and drives a PMOD pin, so the core's button state can feed a second console, or a loopback into the existing controller receiver for bring-up.

---
 rtl/snes_pad_responder_if.sv | 42 ++++
 rtl/snes_pad_responder.sv | 249 ++++++++++++++++++++++++
 tb/tb_snes_pad_responder.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snes_pad_responder_if.sv
// snes_pad_responder_if: pad-side signal bundle of the SNES controller link.
// The optional turbo_mask member exists only when SNES_PAD_TURBO_EN is defined.
interface snes_pad_responder_if;

  logic [15:0] buttons;
  logic        data_latch;
  logic        data_clock;
  logic        serial_data;
  logic        busy;
  logic        frame_done;
  logic [4:0]  bit_index;
`ifdef SNES_PAD_TURBO_EN
  logic [15:0] turbo_mask;
`endif

`ifdef SNES_PAD_TURBO_EN
  // Host / core side: drives buttons and the link, observes the responder.
  modport master (
    output buttons, data_latch, data_clock, turbo_mask,
    input  serial_data, busy, frame_done, bit_index
  );

  // Responder side.
  modport slave (
    input  buttons, data_latch, data_clock, turbo_mask,
    output serial_data, busy, frame_done, bit_index
  );
`else
  // Host / core side: drives buttons and the link, observes the responder.
  modport master (
    output buttons, data_latch, data_clock,
    input  serial_data, busy, frame_done, bit_index
  );

  // Responder side.
  modport slave (
    input  buttons, data_latch, data_clock,
    output serial_data, busy, frame_done, bit_index
  );
`endif

endinterface

// File: rtl/snes_pad_responder.sv
// snes_pad_responder: emulates an SNES game pad on the serial link. Synchronizes
// the host latch/clock, glitch-filters the latch and shifts out the active-low
// button word on serial_data.
// Optional feature: define SNES_PAD_TURBO_EN to add turbo_mask and a frame counter
// that forces masked buttons released on alternating groups of TURBO_FRAMES frames.
module snes_pad_responder #(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned MIN_LATCH_CYCLES = 4,
  parameter int unsigned NUM_BITS         = 16,
  parameter int unsigned TURBO_FRAMES     = 4
) (
  input logic                  clock,
  input logic                  reset,
  snes_pad_responder_if.slave  pad
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned CNT_W  = $clog2(MIN_LATCH_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("snes_pad_responder: SYNC_STAGES must be at least 2");
  end
  if (MIN_LATCH_CYCLES < 1) begin : g_chk_latch
    $error("snes_pad_responder: MIN_LATCH_CYCLES must be at least 1");
  end
  if (NUM_BITS < 1 || NUM_BITS > 31) begin : g_chk_bits
    $error("snes_pad_responder: NUM_BITS must be in 1..31");
  end
  if (TURBO_FRAMES < 1) begin : g_chk_turbo
    $error("snes_pad_responder: TURBO_FRAMES must be at least 1");
  end

  // --------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] latch_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic                   latch_prev_q;
  logic                   clk_prev_q;
  logic                   latch_s;
  logic                   clk_s;
  logic                   latch_fall;
  logic                   clk_rise;

  // Synchronizer chains plus one history flop each; idle levels latch=0, clock=1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      latch_sync_q <= '0;
      clk_sync_q   <= '1;
      latch_prev_q <= 1'b0;
      clk_prev_q   <= 1'b1;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], pad.data_latch};
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], pad.data_clock};
      latch_prev_q <= latch_s;
      clk_prev_q   <= clk_s;
    end
  end

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign clk_s      = clk_sync_q[SYNC_STAGES-1];
  assign latch_fall = latch_prev_q & ~latch_s;
  assign clk_rise   = clk_s & ~clk_prev_q;

  // --------------------------------------------------------------------------
  // Latch glitch filter
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] latch_cnt_q;
  logic [CNT_W-1:0] latch_cnt_d;
  logic             latch_ok;

  // Saturating high-time counter, cleared whenever the synchronized latch is low.
  always_comb begin
    latch_cnt_d = '0;
    if (latch_s) begin
      if (latch_cnt_q >= CNT_W'(MIN_LATCH_CYCLES)) begin
        latch_cnt_d = latch_cnt_q;
      end else begin
        latch_cnt_d = latch_cnt_q + CNT_W'(1);
      end
    end
  end

  // Latch counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      latch_cnt_q <= '0;
    end else begin
      latch_cnt_q <= latch_cnt_d;
    end
  end

  assign latch_ok = (latch_cnt_q >= CNT_W'(MIN_LATCH_CYCLES));

  // --------------------------------------------------------------------------
  // Parallel-load word (optionally turbo-gated)
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0] load_word;
  logic              frame_done_d;

`ifdef SNES_PAD_TURBO_EN
  localparam int unsigned TF_W = $clog2(2 * TURBO_FRAMES);

  logic [TF_W-1:0] frame_cnt_q;
  logic [TF_W-1:0] frame_cnt_d;
  logic            turbo_off;

  // Frame counter advances once per completed frame, wrapping at 2*TURBO_FRAMES.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_done_d) begin
      if (frame_cnt_q == TF_W'(2 * TURBO_FRAMES - 1)) begin
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + TF_W'(1);
      end
    end
  end

  // Frame counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Second half of the turbo period: masked buttons read as released.
  assign turbo_off = (frame_cnt_q >= TF_W'(TURBO_FRAMES));
  assign load_word = ~(pad.buttons & ~(pad.turbo_mask & {WORD_W{turbo_off}}));
`else
  assign load_word = ~pad.buttons;
`endif

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_e            state_q;
  state_e            state_d;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_d;
  logic [IDX_W-1:0]  bit_index_q;
  logic [IDX_W-1:0]  bit_index_d;
  logic              serial_q;
  logic              serial_d;
  logic              busy_q;
  logic              busy_d;
  logic              frame_done_q;

  // Next-state, shift register and output decode; a valid latch always wins.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_index_d  = bit_index_q;
    frame_done_d = 1'b0;
    serial_d     = 1'b1;

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        if (latch_ok) begin
          state_d     = LATCH;
          shift_d     = load_word;
          bit_index_d = '0;
        end
      end

      LATCH: begin
        // Track live buttons until the latch drops; the last load is kept.
        shift_d     = load_word;
        bit_index_d = '0;
        serial_d    = shift_q[0];
        if (latch_fall) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        serial_d = shift_q[0];
        if (latch_ok) begin
          // Host restarted mid-frame: abandon it without frame_done.
          state_d     = LATCH;
          shift_d     = load_word;
          bit_index_d = '0;
        end else if (clk_rise) begin
          shift_d = {1'b0, shift_q[WORD_W-1:1]};
          if (bit_index_q == IDX_W'(NUM_BITS - 1)) begin
            frame_done_d = 1'b1;
            bit_index_d  = IDX_W'(NUM_BITS);
            state_d      = DONE;
          end else begin
            bit_index_d = bit_index_q + IDX_W'(1);
          end
        end
      end

      DONE: begin
        // A real pad returns 0 for every bit past the end of the word.
        serial_d = 1'b0;
        if (latch_ok) begin
          state_d     = LATCH;
          shift_d     = load_word;
          bit_index_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == LATCH) || (state_d == SHIFT);
  end

  // State, data path and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '1;
      bit_index_q  <= '0;
      serial_q     <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_index_q  <= bit_index_d;
      serial_q     <= serial_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pad.serial_data = serial_q;
  assign pad.busy        = busy_q;
  assign pad.frame_done  = frame_done_q;
  assign pad.bit_index   = bit_index_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// tb_snes_pad_responder: drives an SNES host sequence into the responder and
// checks the shifted wire bits against a queue of expected bits.
module tb_snes_pad_responder;

  localparam int unsigned HALF = 50;
  localparam int unsigned TF   = 4;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  snes_pad_responder_if pad_if ();

  snes_pad_responder #(
    .SYNC_STAGES     (2),
    .MIN_LATCH_CYCLES(4),
    .NUM_BITS        (16),
    .TURBO_FRAMES    (TF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pad  (pad_if)
  );

  int   n_checks    = 0;
  int   n_pass      = 0;
  int   fd_seen     = 0;
  int   frames_done = 0;
  logic exp_q[$];

  // Count frame_done pulses (sampled away from the active edge).
  always @(negedge clock) begin
    if (pad_if.frame_done === 1'b1) fd_seen++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Expected wire word for a given button set (active low, turbo-gated).
  function automatic logic [15:0] wire_word(input logic [15:0] b);
    logic [15:0] rel;
    rel = 16'h0000;
`ifdef SNES_PAD_TURBO_EN
    if ((frames_done % (2 * TF)) >= TF) rel = pad_if.turbo_mask;
`endif
    return ~(b & ~rel);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    pad_if.data_latch = 1'b0;
    pad_if.data_clock = 1'b1;
`ifdef SNES_PAD_TURBO_EN
    pad_if.turbo_mask = 16'h0000;
`endif
    cyc(3);
    reset = 1'b0;
    cyc(3);
    frames_done = 0;
    exp_q.delete();
  endtask

  // Drop the latch and queue the frame the pad should now send.
  task automatic end_latch();
    logic [15:0] w;
    pad_if.data_latch = 1'b0;
    w = wire_word(pad_if.buttons);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(w[i]);
    cyc(10);
  endtask

  task automatic latch_frame(input int hi);
    pad_if.data_latch = 1'b1;
    cyc(hi);
    end_latch();
  endtask

  // Clock pulses 'from'..'to'-1, comparing each bit just before its rising edge.
  task automatic shift_bits(input int from, input int to, input string tag);
    logic e;
    for (int i = from; i < to; i++) begin
      pad_if.data_clock = 1'b0;
      cyc(HALF / 2);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL %s bit%0d: got %b, no expected bit queued", tag, i, pad_if.serial_data);
      end else begin
        e = exp_q.pop_front();
        if (pad_if.serial_data !== e)
          $display("FAIL %s bit%0d: got %b expected %b", tag, i, pad_if.serial_data, e);
        else n_pass++;
      end
      cyc(HALF / 2);
      pad_if.data_clock = 1'b1;
      cyc(HALF);
    end
  endtask

  task automatic check_done(input int fd0, input string tag);
    n_checks++;
    if (fd_seen - fd0 !== 1)
      $display("FAIL %s frame_done pulses: got %0d expected 1", tag, fd_seen - fd0);
    else n_pass++;
    n_checks++;
    if (pad_if.serial_data !== 1'b0)
      $display("FAIL %s serial after frame: got %b expected 0", tag, pad_if.serial_data);
    else n_pass++;
    n_checks++;
    if (pad_if.bit_index !== 5'd16)
      $display("FAIL %s bit_index after frame: got %0d expected 16", tag, pad_if.bit_index);
    else n_pass++;
    n_checks++;
    if (pad_if.busy !== 1'b0)
      $display("FAIL %s busy after frame: got %b expected 0", tag, pad_if.busy);
    else n_pass++;
    frames_done++;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (pad_if.serial_data !== 1'b1)
      $display("FAIL reset serial: got %b expected 1", pad_if.serial_data);
    else n_pass++;
    n_checks++;
    if (pad_if.busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", pad_if.busy);
    else n_pass++;
    n_checks++;
    if (pad_if.frame_done !== 1'b0)
      $display("FAIL reset frame_done: got %b expected 0", pad_if.frame_done);
    else n_pass++;
    n_checks++;
    if (pad_if.bit_index !== 5'd0)
      $display("FAIL reset bit_index: got %0d expected 0", pad_if.bit_index);
    else n_pass++;
  endtask

  task automatic test_basic_frame();
    int fd0;
    pad_if.buttons = 16'h0001;
    latch_frame(10);
    fd0 = fd_seen;
    shift_bits(0, 16, "basic");
    check_done(fd0, "basic");
  endtask

  task automatic test_live_load();
    int fd0;
    logic [15:0] w;
    pad_if.buttons = 16'hA5C3;
    pad_if.data_latch = 1'b1;
    cyc(10);
    w = wire_word(16'hA5C3);
    n_checks++;
    if (pad_if.busy !== 1'b1) $display("FAIL live busy in latch: got %b expected 1", pad_if.busy);
    else n_pass++;
    n_checks++;
    if (pad_if.serial_data !== w[0])
      $display("FAIL live serial in latch: got %b expected %b", pad_if.serial_data, w[0]);
    else n_pass++;
    pad_if.buttons = 16'hFFFF;
    cyc(8);
    end_latch();
    pad_if.buttons = 16'h0000;
    fd0 = fd_seen;
    shift_bits(0, 16, "live");
    check_done(fd0, "live");
  endtask

  task automatic test_short_latch();
    int fd0;
    do_reset();
    pad_if.data_latch = 1'b1;
    cyc(2);
    pad_if.data_latch = 1'b0;
    cyc(20);
    n_checks++;
    if (pad_if.busy !== 1'b0) $display("FAIL short idle busy: got %b expected 0", pad_if.busy);
    else n_pass++;
    n_checks++;
    if (pad_if.serial_data !== 1'b1)
      $display("FAIL short idle serial: got %b expected 1", pad_if.serial_data);
    else n_pass++;
    n_checks++;
    if (pad_if.bit_index !== 5'd0)
      $display("FAIL short idle bit_index: got %0d expected 0", pad_if.bit_index);
    else n_pass++;

    pad_if.buttons = 16'h1234;
    latch_frame(10);
    fd0 = fd_seen;
    shift_bits(0, 3, "short");
    pad_if.data_latch = 1'b1;
    cyc(2);
    pad_if.data_latch = 1'b0;
    cyc(20);
    n_checks++;
    if (pad_if.bit_index !== 5'd3)
      $display("FAIL short shift bit_index: got %0d expected 3", pad_if.bit_index);
    else n_pass++;
    n_checks++;
    if (pad_if.busy !== 1'b1) $display("FAIL short shift busy: got %b expected 1", pad_if.busy);
    else n_pass++;
    shift_bits(3, 16, "short");
    check_done(fd0, "short");
  endtask

  task automatic test_abort();
    int fd0;
    logic [15:0] w;
    pad_if.buttons = 16'h00F0;
    latch_frame(10);
    fd0 = fd_seen;
    shift_bits(0, 7, "abort");
    n_checks++;
    if (pad_if.bit_index !== 5'd7)
      $display("FAIL abort bit_index before: got %0d expected 7", pad_if.bit_index);
    else n_pass++;
    // Latch becomes valid in the same cycle the clock rising edge is detected.
    pad_if.data_clock = 1'b0;
    cyc(HALF / 2);
    pad_if.buttons = 16'h0003;
    pad_if.data_latch = 1'b1;
    cyc(4);
    pad_if.data_clock = 1'b1;
    cyc(20);
    w = wire_word(16'h0003);
    n_checks++;
    if (pad_if.bit_index !== 5'd0)
      $display("FAIL abort bit_index: got %0d expected 0", pad_if.bit_index);
    else n_pass++;
    n_checks++;
    if (pad_if.busy !== 1'b1) $display("FAIL abort busy: got %b expected 1", pad_if.busy);
    else n_pass++;
    n_checks++;
    if (fd_seen !== fd0) $display("FAIL abort frame_done: got %0d expected %0d", fd_seen, fd0);
    else n_pass++;
    n_checks++;
    if (pad_if.serial_data !== w[0])
      $display("FAIL abort serial: got %b expected %b", pad_if.serial_data, w[0]);
    else n_pass++;
    end_latch();
    fd0 = fd_seen;
    shift_bits(0, 16, "abort_rerun");
    check_done(fd0, "abort_rerun");
  endtask

  task automatic test_reset_mid_shift();
    int fd0;
    pad_if.buttons = 16'h8421;
    latch_frame(10);
    shift_bits(0, 5, "rst_mid");
    n_checks++;
    if (pad_if.bit_index !== 5'd5)
      $display("FAIL rst_mid bit_index before: got %0d expected 5", pad_if.bit_index);
    else n_pass++;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (pad_if.serial_data !== 1'b1)
      $display("FAIL rst_mid serial: got %b expected 1", pad_if.serial_data);
    else n_pass++;
    n_checks++;
    if (pad_if.busy !== 1'b0) $display("FAIL rst_mid busy: got %b expected 0", pad_if.busy);
    else n_pass++;
    n_checks++;
    if (pad_if.bit_index !== 5'd0)
      $display("FAIL rst_mid bit_index: got %0d expected 0", pad_if.bit_index);
    else n_pass++;
    cyc(3);
    reset = 1'b0;
    cyc(3);
    frames_done = 0;
    exp_q.delete();
    latch_frame(10);
    fd0 = fd_seen;
    shift_bits(0, 16, "rst_rerun");
    check_done(fd0, "rst_rerun");
  endtask

`ifdef SNES_PAD_TURBO_EN
  task automatic test_turbo();
    int fd0;
    logic exp8;
    do_reset();
    pad_if.turbo_mask = 16'h0100;
    pad_if.buttons    = 16'h0100;
    for (int f = 0; f < 9; f++) begin
      exp8 = (f >= 4 && f < 8) ? 1'b1 : 1'b0;
      latch_frame(10);
      fd0 = fd_seen;
      shift_bits(0, 8, "turbo");
      // Bit 8 checked directly against the frame-number rule.
      pad_if.data_clock = 1'b0;
      cyc(HALF / 2);
      n_checks++;
      if (pad_if.serial_data !== exp8)
        $display("FAIL turbo frame%0d bit8: got %b expected %b", f, pad_if.serial_data, exp8);
      else n_pass++;
      cyc(HALF / 2);
      pad_if.data_clock = 1'b1;
      cyc(HALF);
      void'(exp_q.pop_front());
      shift_bits(9, 16, "turbo");
      check_done(fd0, "turbo");
    end
  endtask
`endif

  initial begin
    reset             = 1'b1;
    pad_if.buttons    = 16'h0000;
    pad_if.data_latch = 1'b0;
    pad_if.data_clock = 1'b1;
`ifdef SNES_PAD_TURBO_EN
    pad_if.turbo_mask = 16'h0000;
`endif
    test_reset();
    test_basic_frame();
    test_live_load();
    test_short_latch();
    test_abort();
    test_reset_mid_shift();
`ifdef SNES_PAD_TURBO_EN
    test_turbo();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
